// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle data-memory responder with wait states, Ready/Stall handshake and dual-request error.
module dm_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Ready,
  output logic             Stall,
  output logic             Err,
  output logic [CNT_W-1:0] AccessCount
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       mem [0:(2**ADDR_W)-1];

  logic              legal_req, dual_req, accept, enter_done;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^Addr[31:ADDR_W];

  assign legal_req = MemRead ^ MemWrite;
  assign dual_req  = MemRead & MemWrite;
  assign accept    = (state == S_IDLE) && legal_req;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt <= 4'd1) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign enter_done = (next_state == S_DONE) && (state != S_DONE);

  // With zero wait states the access completes on the accept edge, so use the live inputs.
  assign acc_wr   = accept ? MemWrite : op_wr_q;
  assign acc_addr = accept ? Addr[ADDR_W-1:0] : addr_q;
  assign acc_data = accept ? WriteData : data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= 32'd0;
      ReadData    <= 32'd0;
      Err         <= 1'b0;
      AccessCount <= '0;
    end else begin
      state <= next_state;
      Err   <= (state == S_IDLE) && dual_req;
      if (accept) begin
        op_wr_q <= MemWrite;
        addr_q  <= Addr[ADDR_W-1:0];
        data_q  <= WriteData;
        cnt     <= WAIT_LD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !acc_wr)
        ReadData <= mem[acc_addr];
      if (enter_done && AccessCount != '1)
        AccessCount <= AccessCount + CNT_W'(1);
    end
  end

  // Memory contents survive reset; a reset on the completing edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && enter_done && acc_wr)
      mem[acc_addr] <= acc_data;
  end

  assign Ready = (state == S_DONE);
  assign Stall = accept || (state == S_WAIT);

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder with randomized traffic and a reference memory model.
module tb_dm_responder;

  localparam int W   = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mem_read, mem_write;
  logic [31:0]   addr, wdata, rdata;
  logic          ready, stall, err;
  logic [CW-1:0] acnt;

  logic          rd0, wr0;
  logic [31:0]   addr0, wdata0, rdata0;
  logic          ready0, stall0, err0;
  logic [15:0]   acnt0;

  dm_responder #(.ADDR_W(8), .WAIT_CYCLES(W), .CNT_W(CW)) u_dut (
    .CLK(clk), .RST(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .WriteData(wdata), .ReadData(rdata), .Ready(ready),
    .Stall(stall), .Err(err), .AccessCount(acnt)
  );

  dm_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .CNT_W(16)) u_dut0 (
    .CLK(clk), .RST(rst), .MemRead(rd0), .MemWrite(wr0),
    .Addr(addr0), .WriteData(wdata0), .ReadData(rdata0), .Ready(ready0),
    .Stall(stall0), .Err(err0), .AccessCount(acnt0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rd;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          err_pending = 0;
  logic [31:0] ref_mem [256];
  int          ref_cnt;
  logic [31:0] ref_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_ready");
      else begin
        mon_e = exp_q.pop_front();
        chk("read_data", rdata, mon_e.rd);
        chk("access_count", 32'(acnt), 32'(mon_e.cnt));
      end
    end
    if (err) begin
      if (err_pending == 0) fail_now("unexpected_err");
      else err_pending--;
    end
  end

  // Called #1 after a rising edge; returns #1 after the rising edge that leaves DONE.
  task automatic do_access(input bit rd, input logic [31:0] a, input logic [31:0] d, input bit drop);
    exp_t e;
    bit   done;
    ref_cnt = (ref_cnt < SAT) ? ref_cnt + 1 : SAT;
    if (rd) ref_last = ref_mem[a[7:0]];
    else    ref_mem[a[7:0]] = d;
    e.rd  = ref_last;
    e.cnt = ref_cnt;
    exp_q.push_back(e);
    mem_read  = rd;
    mem_write = !rd;
    addr      = a;
    wdata     = d;
    done      = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      chk("stall", 32'(stall), 32'(k <= W + 1));
      if (ready) begin
        chk("latency", k, W + 2);
        done = 1;
      end else begin
        @(posedge clk);
        #1;
        if (k == 1 && drop) begin
          mem_read  = 0;
          mem_write = 0;
          addr      = $urandom;
          wdata     = $urandom;
        end
      end
    end
    if (!done) fail_now("ready_timeout");
    @(posedge clk);
    #1;
    mem_read  = 0;
    mem_write = 0;
    addr      = $urandom;
    wdata     = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    rst = 1; mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    ref_cnt = 0; ref_last = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_count", 32'(acnt), 0);
    chk("rst_stall", 32'(stall), 0);
    @(posedge clk); #1;

    do_access(0, 32'h05, 32'hDEADBEEF, 0);
    chk("count_after_write", 32'(acnt), 1);
    do_access(1, 32'h105, 32'h0, 0);
    chk("alias_read", rdata, 32'hDEADBEEF);

    for (int i = 0; i < 256; i++) begin
      if (i == 5) continue;
      a = {$urandom_range(0, 32'hFFFFFF), 8'(i)};
      d = $urandom;
      do_access(0, a, d, bit'($urandom_range(0, 1)));
    end

    mem_read = 1; mem_write = 1; addr = 32'h10;
    err_pending++;
    @(negedge clk);
    chk("dual_stall", 32'(stall), 0);
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    @(negedge clk);
    chk("err_pulse", 32'(err), 1);
    chk("dual_count", 32'(acnt), 32'(ref_cnt));
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 0);
    @(posedge clk); #1;
    do_access(1, 32'h10, 32'h0, 0);

    do_access(0, 32'h20, 32'hA5A50020, 0);
    mem_write = 1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 1);
    @(posedge clk); #1;
    rst = 1; mem_write = 0;
    @(posedge clk); #1;
    rst = 0;
    ref_cnt = 0; ref_last = 0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_count", 32'(acnt), 0);
    chk("abort_stall", 32'(stall), 0);
    @(posedge clk); #1;
    do_access(1, 32'h20, 32'h0, 0);

    do_access(0, 32'h333, 32'hCAFEF00D, 0);
    do_access(1, 32'h33, 32'h0, 0);
    repeat (80) begin
      a = $urandom;
      d = $urandom;
      do_access(bit'($urandom_range(0, 1)), a, d, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    chk("count_saturated", 32'(acnt), SAT);

    wr0 = 1; addr0 = 1; wdata0 = 32'h11110001;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("w0_stall", 32'(stall0), 32'(k % 2));
      chk("w0_ready", 32'(ready0), 32'(k % 2 == 0));
      @(posedge clk); #1;
      if (k == 2) begin addr0 = 2; wdata0 = 32'h22220002; end
    end
    wr0 = 0;
    rd0 = 1; addr0 = 1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("r0_stall", 32'(stall0), 32'(k % 2));
      chk("r0_ready", 32'(ready0), 32'(k % 2 == 0));
      if (ready0) chk("r0_data", rdata0, (addr0 == 1) ? 32'h11110001 : 32'h22220002);
      @(posedge clk); #1;
      if (k % 2 == 0) addr0 = (addr0 == 1) ? 32'd2 : 32'd1;
    end
    rd0 = 0;
    @(negedge clk);
    chk("r0_count", 32'(acnt0), 6);
    chk("r0_hold", rdata0, 32'h22220002);
    chk("r0_err", 32'(err0), 0);

    repeat (4) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_pending, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
